mult_div_ctrl: RTL and testbench
================================

MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port Start, input, 1 bit: the EX stage issues MDOp this cycle.
REQ-004 The block SHALL have port MDOp, input, 3 bits: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is reserved and treated as none.
REQ-005 The block SHALL have port A, input, 32 bits: the rs operand (multiplicand or dividend; source for MTHI/MTLO).
REQ-006 The block SHALL have port B, input, 32 bits: the rt operand (multiplier or divisor).
REQ-007 The block SHALL have port Flush, input, 1 bit: exception or flush; aborts the in-flight operation.
REQ-008 The block SHALL have port Busy, output, 1 bit: high while an iterative operation is in flight; the hazard unit stalls MFHI/MFLO and new MD ops on it.
REQ-009 The block SHALL have port HI, output, 32 bits: architectural HI register.
REQ-010 The block SHALL have port LO, output, 32 bits: architectural LO register.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, ITER, FIX.
REQ-012 In IDLE, Start=1 with MDOp 1-4 SHALL latch operand magnitudes and sign flags, clear the 6-bit iteration counter, and move to ITER at the next edge.
REQ-013 Signed ops (MULT, DIV) SHALL use |A| and |B| (two's-complement negation); unsigned ops SHALL use A and B raw.
REQ-014 ITER SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle for exactly 32 cycles, then enter FIX.
REQ-015 FIX SHALL apply sign correction and write HI/LO at the edge leaving FIX, then return to IDLE.
REQ-016 Sign correction for MULT: the 64-bit product SHALL be negated when sign(A) differs from sign(B); HI is product[63:32] and LO is product[31:0].
REQ-017 Sign correction for DIV: the quotient SHALL be negated when the signs differ, and the remainder SHALL take the sign of A; LO is the quotient and HI is the remainder.
REQ-018 Overflow case 0x80000000 DIV 0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0, with no trap.
REQ-019 Divide by zero (B=0, DIV or DIVU) SHALL take the full latency and yield LO=0xFFFFFFFF and HI=A (the original, uncorrected A).
REQ-020 Busy SHALL be 1 in ITER and FIX and 0 in IDLE, so it is high for exactly 33 cycles per MD op; results are visible the cycle Busy falls.
REQ-021 MTHI/MTLO with Start=1 in IDLE SHALL write A to HI or LO at the next edge, without asserting Busy.
REQ-022 Start while Busy=1, of any op including MTHI/MTLO, SHALL be ignored with no state change; the pipeline guarantees a stall.
REQ-023 Start with MDOp 0 or 7 SHALL be a no-op.
REQ-024 Flush=1 in ITER or FIX SHALL force IDLE at the next edge, leave HI/LO unchanged, and drop Busy at that edge.
REQ-025 Flush=1 in IDLE SHALL suppress any Start in the same cycle.
REQ-026 Flush SHALL have priority over Start.
REQ-027 HI and LO SHALL change only at FIX exit, on MTHI/MTLO, or on reset.

Reset
REQ-028 rst_n=0 SHALL immediately and asynchronously set the state to IDLE, Busy=0, HI=0, LO=0, the counter to 0, and clear all datapath registers.
REQ-029 Reset asserted mid-operation SHALL discard the operation; after rst_n rises the block SHALL accept Start on the first clock edge.

Verification
REQ-030 The bench SHALL cover: MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Busy high 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 The bench SHALL cover: MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
REQ-032 The bench SHALL cover: DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); and DIVU A=7, B=0 -> LO=0xFFFFFFFF, HI=7.
REQ-033 The bench SHALL cover: DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-034 The bench SHALL cover: MTLO A=0x12345678 while idle -> LO=0x12345678 next edge with Busy=0; then MULT started and a second MTHI issued during Busy -> MTHI ignored, HI equals the product's high word.
REQ-035 The bench SHALL cover: MULT started, Flush at ITER cycle 10 -> Busy=0 next edge and HI/LO keep prior values; separately, rst_n pulsed low at ITER cycle 20 -> HI=LO=0 and Busy=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mult_div_ctrl_if.sv
// mult_div_ctrl_if: EX-stage to multiply/divide unit handshake and HI/LO result bus.
interface mult_div_ctrl_if;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    modport master (output Start, MDOp, A, B, Flush, input Busy, HI, LO);
    modport slave  (input Start, MDOp, A, B, Flush, output Busy, HI, LO);
endinterface

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: iterative 32-bit MIPS multiply/divide unit owning the HI/LO registers.
module mult_div_ctrl (
    input logic            clk,
    input logic            rst_n,
    mult_div_ctrl_if.slave md
);
    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] mb;
    logic [63:0] p;
    logic        is_div, sa, sb;
    logic        op_signed, op_md, op_div, sgn_a, sgn_b, ge;
    logic [31:0] mag_a, mag_b, sub, q_fix, r_fix;
    logic [32:0] msum;
    logic [63:0] p_nxt, prod_fix;
    // p holds {hi_acc, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin
        op_signed = md.MDOp == 3'd1 || md.MDOp == 3'd3;
        op_md     = md.MDOp >= 3'd1 && md.MDOp <= 3'd4;
        op_div    = md.MDOp == 3'd3 || md.MDOp == 3'd4;
        sgn_a     = op_signed & md.A[31];
        sgn_b     = op_signed & md.B[31];
        mag_a     = sgn_a ? -md.A : md.A;
        mag_b     = sgn_b ? -md.B : md.B;
        msum      = {1'b0, p[63:32]} + (p[0] ? {1'b0, mb} : 33'd0);
        ge        = p[63:31] >= {1'b0, mb};
        sub       = p[62:31] - mb;
        p_nxt     = is_div ? (ge ? {sub, p[30:0], 1'b1} : {p[62:0], 1'b0}) : {msum, p[31:1]};
        prod_fix  = (sa ^ sb) ? -p : p;
        q_fix     = (mb == 32'd0) ? 32'hFFFF_FFFF : ((sa ^ sb) ? -p[31:0] : p[31:0]);
        r_fix     = sa ? -p[63:32] : p[63:32];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            mb      <= '0;
            p       <= '0;
            is_div  <= 1'b0;
            sa      <= 1'b0;
            sb      <= 1'b0;
            md.Busy <= 1'b0;
            md.HI   <= '0;
            md.LO   <= '0;
        end else begin
            case (state)
                IDLE: if (md.Start && !md.Flush) begin
                    if (op_md) begin
                        mb      <= mag_b;
                        p       <= {32'd0, mag_a};
                        is_div  <= op_div;
                        sa      <= sgn_a;
                        sb      <= sgn_b;
                        cnt     <= '0;
                        md.Busy <= 1'b1;
                        state   <= ITER;
                    end
                    if (md.MDOp == 3'd5) md.HI <= md.A;
                    if (md.MDOp == 3'd6) md.LO <= md.A;
                end
                ITER: if (md.Flush) begin
                    md.Busy <= 1'b0;
                    state   <= IDLE;
                end else begin
                    p   <= p_nxt;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) state <= FIX;
                end
                FIX: begin
                    if (!md.Flush) begin
                        md.HI <= is_div ? r_fix : prod_fix[63:32];
                        md.LO <= is_div ? q_fix : prod_fix[31:0];
                    end
                    md.Busy <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_ctrl.sv
// tb_mult_div_ctrl: vector table plus hand-written flush/reset/hazard sequences, scoreboard-checked.
module tb_mult_div_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_div_ctrl_if bif();
    mult_div_ctrl dut (.clk(clk), .rst_n(rst_n), .md(bif));

    typedef struct {logic [2:0] op; logic [31:0] a, b, hi, lo;} vec_t;
    typedef struct {logic [31:0] hi, lo;} exp_t;
    exp_t sbq[$];
    vec_t vt[12];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl);
        @(negedge clk);
        bif.Start = 1'b1; bif.MDOp = op; bif.A = a; bif.B = b; bif.Flush = fl;
        @(negedge clk);
        bif.Start = 1'b0; bif.MDOp = 3'd0; bif.Flush = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bif.Busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic compare_pop(input string name);
        exp_t e;
        if (sbq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sbq.pop_front();
            check({name, " HI"}, bif.HI, e.hi);
            check({name, " LO"}, bif.LO, e.lo);
        end
    endtask

    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, input string name);
        int n;
        sbq.push_back('{hi, lo});
        issue(op, a, b, 1'b0);
        wait_idle(n);
        check({name, " busy_cycles"}, n, 33);
        compare_pop(name);
    endtask

    task automatic run_mt(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] hi, input logic [31:0] lo, input string name);
        sbq.push_back('{hi, lo});
        issue(op, a, 32'd0, 1'b0);
        check({name, " busy"}, {31'd0, bif.Busy}, 0);
        compare_pop(name);
    endtask

    initial begin
        int n;
        bif.Start = 1'b0; bif.MDOp = 3'd0; bif.A = '0; bif.B = '0; bif.Flush = 1'b0;
        vt[0]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vt[1]  = '{3'd1, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vt[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vt[3]  = '{3'd4, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF};
        vt[4]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vt[5]  = '{3'd4, 32'd100,       32'd7,         32'd2,         32'd14};
        vt[6]  = '{3'd1, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vt[7]  = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vt[8]  = '{3'd3, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vt[9]  = '{3'd2, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0};
        vt[10] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
        vt[11] = '{3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         32'd1};

        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, bif.Busy}, 0);
        check("reset HI", bif.HI, 0);
        check("reset LO", bif.LO, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            run_md(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, $sformatf("vec%0d", i));

        run_mt(3'd6, 32'h1234_5678, 32'd1, 32'h1234_5678, "mtlo");
        run_mt(3'd5, 32'hAAAA_5555, 32'hAAAA_5555, 32'h1234_5678, "mthi");

        // new ops issued while busy must be ignored
        sbq.push_back('{32'd0, 32'd15});
        issue(3'd1, 32'd3, 32'd5, 1'b0);
        repeat (4) @(negedge clk);
        bif.Start = 1'b1; bif.MDOp = 3'd5; bif.A = 32'hDEAD_BEEF;
        @(negedge clk);
        bif.MDOp = 3'd1; bif.A = 32'd2; bif.B = 32'd2;
        @(negedge clk);
        bif.Start = 1'b0; bif.MDOp = 3'd0;
        wait_idle(n);
        check("busy_ignore cycles", n, 27);
        compare_pop("busy_ignore");

        issue(3'd7, 32'h1111_1111, 32'd3, 1'b0);
        check("op7 busy", {31'd0, bif.Busy}, 0);
        check("op7 HI", bif.HI, 0);
        check("op7 LO", bif.LO, 15);
        issue(3'd0, 32'h1111_1111, 32'd3, 1'b0);
        check("op0 busy", {31'd0, bif.Busy}, 0);

        // flush in ITER
        issue(3'd1, 32'h1234, 32'h5678, 1'b0);
        repeat (9) @(negedge clk);
        check("flush pre busy", {31'd0, bif.Busy}, 1);
        bif.Flush = 1'b1;
        @(negedge clk);
        bif.Flush = 1'b0;
        check("flush busy", {31'd0, bif.Busy}, 0);
        repeat (40) @(negedge clk);
        check("flush HI", bif.HI, 0);
        check("flush LO", bif.LO, 15);

        // flush in IDLE suppresses start
        issue(3'd6, 32'hFFFF_0000, 32'd0, 1'b1);
        check("idle flush LO", bif.LO, 15);
        issue(3'd1, 32'd3, 32'd3, 1'b1);
        check("idle flush busy", {31'd0, bif.Busy}, 0);

        run_mt(3'd5, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 32'd15, "mthi2");

        // async reset mid-operation
        issue(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy", {31'd0, bif.Busy}, 0);
        check("async rst HI", bif.HI, 0);
        check("async rst LO", bif.LO, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        run_md(3'd1, 32'd6, 32'd7, 32'd0, 32'd42, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
